// File: rtl/ff4_load_arbiter.sv
// Round-robin arbiter and load/readback sequencer for one shared negedge-capture register.
// Optional macro ARB_LOCK_EN: a locked winner holding req is re-granted without advancing ptr.
module ff4_load_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]         lock,
    input  logic                    err_clr,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    ff_load,
    output logic [WIDTH-1:0]        ff_d,
    input  logic [WIDTH-1:0]        ff_q,
    output logic                    busy,
    output logic                    err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [PW-1:0]    ptr, ptr_next;
    logic [PW-1:0]    winner, winner_next;
    logic [WIDTH-1:0] data, data_next;
    logic             relock, relock_next;
    logic             err_next;
    logic [NREQ-1:0]  cand;
    logic             found;
    logic [PW-1:0]    pick;
    logic             lock_hit;

`ifdef ARB_LOCK_EN
    assign lock_hit = (state == VERIFY) && lock[winner] && req[winner];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign lock_hit    = 1'b0;
`endif

    // The requester being acked still holds req, so it is excluded from the next pick.
    always_comb begin
        cand = req;
        if (state == VERIFY) begin
            cand[winner] = 1'b0;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && cand[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        winner_next = winner;
        data_next   = data;
        relock_next = relock;
        case (state)
            IDLE: begin
                relock_next = 1'b0;
                if (found) begin
                    state_next  = LOAD;
                    winner_next = pick;
                    data_next   = req_data[int'(pick)*WIDTH +: WIDTH];
                end
            end
            LOAD: begin
                state_next = VERIFY;
                if (!relock) begin
                    ptr_next = PW'((int'(winner) + 1) % NREQ);
                end
            end
            VERIFY: begin
                if (lock_hit) begin
                    state_next  = LOAD;
                    data_next   = req_data[int'(winner)*WIDTH +: WIDTH];
                    relock_next = 1'b1;
                end else if (found) begin
                    state_next  = LOAD;
                    winner_next = pick;
                    data_next   = req_data[int'(pick)*WIDTH +: WIDTH];
                    relock_next = 1'b0;
                end else begin
                    state_next  = IDLE;
                    relock_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A mismatch in the same cycle as err_clr wins so the new error is never lost.
    assign err_next = ((state == VERIFY) && (ff_q != data)) || (err && !err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
            data   <= '0;
            relock <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            winner <= winner_next;
            data   <= data_next;
            relock <= relock_next;
            err    <= err_next;
        end
    end

    assign gnt     = (state == LOAD)   ? (NREQ'(1) << winner) : '0;
    assign ack     = (state == VERIFY) ? (NREQ'(1) << winner) : '0;
    assign ff_load = (state == LOAD);
    assign ff_d    = (state == IDLE) ? '0 : data;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ff4_load_arbiter.sv
// Bench for ff4_load_arbiter: directed vector table, reset/lock sequences, randomized run vs a model.
module tb_ff4_load_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [N*W-1:0] req_data = '0;
    logic           err_clr = 1'b0;
    logic [N-1:0]   gnt, ack;
    logic           ff_load;
    logic [W-1:0]   ff_d, ff_q;
    logic           busy, err;

    logic [W-1:0]   shadow = '0;
    logic           qf_en = 1'b0;
    logic [W-1:0]   qf = '0;

    int vecs = 0;
    int miss = 0;

    ff4_load_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .lock(lock),
        .err_clr(err_clr), .gnt(gnt), .ack(ack), .ff_load(ff_load), .ff_d(ff_d),
        .ff_q(ff_q), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Shared register outside the arbiter: captures on negedge, optionally overridden.
    always @(negedge clk) if (ff_load) shadow <= ff_d;
    assign ff_q = qf_en ? qf : shadow;

    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic [15:0] dt;
        logic        c;
        logic        qe;
        logic [3:0]  q;
        logic [3:0]  g;
        logic [3:0]  a;
        logic        l;
        logic [3:0]  d;
        logic        b;
        logic        e;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [15:0] dt, logic c, logic qe,
                                logic [3:0] q, logic [3:0] g, logic [3:0] a, logic l,
                                logic [3:0] d, logic b, logic e);
        vec_t v;
        v.r = r; v.rq = rq; v.dt = dt; v.c = c; v.qe = qe; v.q = q;
        v.g = g; v.a = a; v.l = l; v.d = d; v.b = b; v.e = e;
        return v;
    endfunction

    function automatic logic [14:0] pk(logic [3:0] g, logic [3:0] a, logic l, logic [3:0] d,
                                       logic b, logic e);
        return {g, a, l, d, b, e};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h (gnt,ack,load,d,busy,err)", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [14:0] exp);
        chk(name, pk(gnt, ack, ff_load, ff_d, busy, err), exp);
    endtask

    task automatic wait_gnt(output int w);
        w = -1;
        for (int c = 0; c < 10 && w < 0; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (gnt[i]) w = i;
        end
        if (w < 0) begin
            vecs++;
            miss++;
            $display("FAIL wait_gnt: no grant within 10 cycles, required one");
        end
    endtask

    function automatic int rr_pick(logic [N-1:0] m, int start);
        for (int k = 0; k < N; k++) if (m[(start + k) % N]) return (start + k) % N;
        return 0;
    endfunction

    // Reference model state: phase 0 idle, 1 register being loaded, 2 readback/ack.
    int           mph, mwin, mptr;
    logic [W-1:0] mdata;
    logic         merr;

    initial begin
        int w;
        int exp_seq[4];
        logic [N-1:0] cset;
        logic [W-1:0] q_s;
        logic         e_n;

        tbl[0]  = mk(1, 4'b0100, 16'h0A00, 0, 0, 0, 4'b0100, 4'b0000, 1, 4'hA, 1, 0);
        tbl[1]  = mk(1, 4'b0100, 16'h0A00, 0, 0, 0, 4'b0000, 4'b0100, 0, 4'hA, 1, 0);
        tbl[2]  = mk(1, 4'b0000, 16'h0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0, 0);
        tbl[3]  = mk(0, 4'b0000, 16'h0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0, 0);
        tbl[4]  = mk(1, 4'b1111, 16'h4321, 0, 0, 0, 4'b0001, 4'b0000, 1, 4'h1, 1, 0);
        tbl[5]  = mk(1, 4'b1111, 16'h4321, 0, 0, 0, 4'b0000, 4'b0001, 0, 4'h1, 1, 0);
        tbl[6]  = mk(1, 4'b1110, 16'h4321, 0, 0, 0, 4'b0010, 4'b0000, 1, 4'h2, 1, 0);
        tbl[7]  = mk(1, 4'b1110, 16'h4321, 0, 0, 0, 4'b0000, 4'b0010, 0, 4'h2, 1, 0);
        tbl[8]  = mk(1, 4'b1100, 16'h4321, 0, 0, 0, 4'b0100, 4'b0000, 1, 4'h3, 1, 0);
        tbl[9]  = mk(1, 4'b1100, 16'h4321, 0, 0, 0, 4'b0000, 4'b0100, 0, 4'h3, 1, 0);
        tbl[10] = mk(1, 4'b1000, 16'h4321, 0, 0, 0, 4'b1000, 4'b0000, 1, 4'h4, 1, 0);
        tbl[11] = mk(1, 4'b1000, 16'h4321, 0, 0, 0, 4'b0000, 4'b1000, 0, 4'h4, 1, 0);
        tbl[12] = mk(1, 4'b1001, 16'h9007, 0, 0, 0, 4'b0001, 4'b0000, 1, 4'h7, 1, 0);
        tbl[13] = mk(1, 4'b1001, 16'h9007, 0, 0, 0, 4'b0000, 4'b0001, 0, 4'h7, 1, 0);
        tbl[14] = mk(1, 4'b1000, 16'h9007, 0, 0, 0, 4'b1000, 4'b0000, 1, 4'h9, 1, 0);
        tbl[15] = mk(1, 4'b1000, 16'h9007, 0, 0, 0, 4'b0000, 4'b1000, 0, 4'h9, 1, 0);
        tbl[16] = mk(1, 4'b0000, 16'h0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0, 0);
        tbl[17] = mk(1, 4'b0001, 16'h0006, 0, 0, 0, 4'b0001, 4'b0000, 1, 4'h6, 1, 0);
        tbl[18] = mk(1, 4'b0001, 16'h0006, 0, 0, 0, 4'b0000, 4'b0001, 0, 4'h6, 1, 0);
        tbl[19] = mk(1, 4'b0000, 16'h0000, 0, 1, 5, 4'b0000, 4'b0000, 0, 4'h0, 0, 1);
        tbl[20] = mk(1, 4'b0000, 16'h0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0, 1);
        tbl[21] = mk(1, 4'b0000, 16'h0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0, 0);
        tbl[22] = mk(1, 4'b0010, 16'h0060, 0, 0, 0, 4'b0010, 4'b0000, 1, 4'h6, 1, 0);
        tbl[23] = mk(1, 4'b0010, 16'h0060, 0, 0, 0, 4'b0000, 4'b0010, 0, 4'h6, 1, 0);
        tbl[24] = mk(1, 4'b0000, 16'h0000, 1, 1, 5, 4'b0000, 4'b0000, 0, 4'h0, 0, 1);
        tbl[25] = mk(1, 4'b0000, 16'h0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0, 0);
        tbl[26] = mk(1, 4'b0000, 16'h0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'h0, 0, 0);

        #2;
        chk_outs("reset_state", 15'd0);
        #10;

        for (int i = 0; i < 27; i++) begin
            rst_n    = tbl[i].r;
            req      = tbl[i].rq;
            req_data = tbl[i].dt;
            err_clr  = tbl[i].c;
            qf_en    = tbl[i].qe;
            qf       = tbl[i].q;
            @(posedge clk); #1;
            chk_outs($sformatf("row%0d", i),
                     pk(tbl[i].g, tbl[i].a, tbl[i].l, tbl[i].d, tbl[i].b, tbl[i].e));
        end

        // Reset during LOAD: ptr is 2 here, so a restart from ptr 0 picks requester 1 first.
        req = 4'b0110; req_data = 16'h0BC0;
        @(posedge clk); #1;
        chk_outs("pre_reset_load", pk(4'b0100, 4'b0000, 1, 4'hB, 1, 0));
        #2 rst_n = 1'b0;
        #1 chk_outs("async_reset_drop", 15'd0);
        @(posedge clk); #1;
        chk_outs("reset_no_ack", 15'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_outs("restart_load", pk(4'b0010, 4'b0000, 1, 4'hC, 1, 0));
        @(posedge clk); #1;
        chk_outs("restart_verify", pk(4'b0000, 4'b0010, 0, 4'hC, 1, 0));
        req = 4'b0100;
        @(posedge clk); #1;
        chk_outs("after_restart_load", pk(4'b0100, 4'b0000, 1, 4'hB, 1, 0));
        @(posedge clk); #1;
        chk_outs("after_restart_verify", pk(4'b0000, 4'b0100, 0, 4'hB, 1, 0));
        req = 4'b0000;
        @(posedge clk); #1;
        chk_outs("after_restart_idle", 15'd0);

        // Lock hint sequence.
        rst_n = 1'b0; #3 rst_n = 1'b1;
`ifdef ARB_LOCK_EN
        exp_seq = '{1, 1, 1, 2};
`else
        exp_seq = '{1, 2, 1, 2};
`endif
        req = 4'b0110; req_data = 16'h0DE0; lock = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(w);
            chk($sformatf("lock_grant%0d", k), 15'(w), 15'(exp_seq[k]));
            if (k == 2) lock = 4'b0000;
        end
        req = 4'b0000; lock = 4'b0000;
        repeat (3) @(posedge clk);

        // Randomized run against the reference model.
        #1 rst_n = 1'b0; #2 rst_n = 1'b1;
        mph = 0; mwin = 0; mptr = 0; mdata = '0; merr = 1'b0;
        req = '0; err_clr = 1'b0; qf_en = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            q_s = ff_q;
            e_n = ((mph == 2) && (q_s != mdata)) || (merr && !err_clr);
            case (mph)
                0: if (req != 0) begin
                       mwin = rr_pick(req, mptr); mdata = req_data[mwin*W +: W]; mph = 1;
                   end
                1: begin mph = 2; mptr = (mwin + 1) % N; end
                default: begin
                    cset = req & ~(N'(1) << mwin);
                    if (cset != 0) begin
                        mwin = rr_pick(cset, mptr); mdata = req_data[mwin*W +: W]; mph = 1;
                    end else mph = 0;
                end
            endcase
            merr = e_n;
            #1;
            chk($sformatf("rand%0d", cyc), pk(gnt, ack, ff_load, ff_d, busy, err),
                pk((mph == 1) ? 4'(N'(1) << mwin) : 4'h0,
                   (mph == 2) ? 4'(N'(1) << mwin) : 4'h0,
                   mph == 1, (mph == 0) ? 4'h0 : mdata, mph != 0, merr));
            for (int i = 0; i < N; i++) begin
                if (mph == 2 && mwin == i) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*W +: W] = W'($urandom);
                end else if (req[i] && mph == 0 && $urandom_range(0, 15) == 0) req[i] = 1'b0;
            end
            err_clr = ($urandom_range(0, 7) == 0);
            qf_en   = ($urandom_range(0, 5) == 0);
            qf      = W'($urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/ff4_load_arbiter.md
Name: ff4_load_arbiter

Overview:
- Round-robin arbiter and load sequencer sharing one 4-bit negedge-capture load register among NREQ requesters.
- Grants one requester at a time and drives the register's load and d inputs for exactly one cycle.
- Reads back the register q, checks it against the loaded value, and acks the requester.
- Sits between requester logic and the shared register; the controller itself runs on posedge clk.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, data width of the shared register.

Ports:
- clk  input  1  system clock; all controller state updates on posedge.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- req  input  NREQ  per-requester load request, level, held until ack.
- req_data  input  NREQ*WIDTH  per-requester data; slice i = bits [i*WIDTH +: WIDTH].
- lock  input  NREQ  per-requester grant-lock hint; used only with ARB_LOCK_EN.
- err_clr  input  1  synchronous clear of err.
- gnt  output  NREQ  one-hot; high during the LOAD cycle of the winner.
- ack  output  NREQ  one-hot one-cycle pulse during the VERIFY cycle.
- ff_load  output  1  load enable to the shared register.
- ff_d  output  WIDTH  data to the shared register.
- ff_q  input  WIDTH  shared register output, for readback.
- busy  output  1  high whenever state != IDLE.
- err  output  1  sticky readback-mismatch flag.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0 immediately, i.e. gnt=0, ack=0, ff_load=0, ff_d=0, busy=0, err=0. Internal state goes to 0: state=IDLE, ptr=0, winner=0, latched data=0.
- Reset mid-transaction aborts it with no ack. The shared register is not reset by this block.
- States: IDLE, LOAD, VERIFY.
- IDLE:
  - If any req is high, at the next posedge: winner = first set req at or after ptr (ascending, wrapping mod NREQ); latch req_data[winner]; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (one cycle): gnt[winner]=1, ff_load=1, ff_d=latched data. The register captures on the negedge inside this cycle. At the next posedge go to VERIFY and set ptr = (winner+1) mod NREQ.
- VERIFY (one cycle):
  - ack[winner]=1, ff_load=0, ff_d holds the latched data.
  - If ff_q != latched data, set err at the posedge ending this cycle.
  - Arbitration runs as in IDLE, but req[winner] is masked (the requester drops req only after seeing ack).
  - If a candidate exists, go directly to LOAD with the new winner and data; otherwise go to IDLE.
- Latency: req high at posedge k in IDLE gives gnt/ff_load in cycle k+1 and ack in cycle k+2. Sustained back-to-back throughput is one load per 2 cycles.
- Requester contract: req_data need only be valid in the cycle the grant decision is made; it is latched.
- A req dropped before grant has no effect. A req dropped after grant is ignored: the transaction completes and ack still pulses.
- Fairness: any requester holding req is granted within NREQ transactions.
- err: set on mismatch; cleared by err_clr. Simultaneous set and clear leaves err=1 (the new error is not lost).
- NREQ=1: ptr is always 0. The winner mask in VERIFY forces a return to IDLE between loads.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: in VERIFY, if lock[winner] and req[winner] are both high, the winner is not masked and is re-granted before any other requester; ptr is not advanced for a locked re-grant.
- Undefined: the lock input is ignored (left unconnected internally) and behaviour is exactly as above.

Test Plan:
- After reset, req[2]=1, req_data slice 2=4'hA: next cycle gnt=4'b0100, ff_load=1, ff_d=4'hA; following cycle ack=4'b0100, ff_q=4'hA, err=0; then busy=0.
- req=4'b1111 held, each requester dropping its req after its ack, distinct data 1,2,3,4: grants in order 0,1,2,3 with no IDLE cycle between transactions; each ff_d matches its requester.
- Wrap: ptr=0 after last grant to 3; req[0] and req[3] asserted together -> req 0 granted first, then 3.
- Bench drives ff_q=4'h5 while loading 4'h6 -> err=1 after VERIFY and stays sticky. err_clr pulse -> err=0. err_clr coincident with a new mismatch -> err=1.
- rst_n pulsed low during LOAD -> gnt, ff_load, ff_d, busy drop to 0 asynchronously, no ack. With req still held after release -> transaction restarts from ptr=0.
- ARB_LOCK_EN defined: lock[1]=1, req[1]=req[2]=1 held -> three consecutive grants to 1; after lock[1]=0 -> next grant goes to 2. Macro undefined -> grants alternate 1,2.
